// File: rtl/thunderbird_pkg.sv
// Shared types and helpers for the parametrised tail-light sequencer.
package thunderbird_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2,
      HAZ   = 2'd3
   } state_e;

   // Widest lamp bank the thermometer helper can describe.
   localparam int THERM_MAX = 32;

   // Thermometer code with the k lowest bits set, clipped to the lamp count.
   function automatic logic [THERM_MAX-1:0] therm(input int k, input int lamps);
      logic [THERM_MAX-1:0] t;
      t = '0;
      for (int i = 0; i < THERM_MAX; i++) begin
         if ((i < k) && (i < lamps)) t[i] = 1'b1;
      end
      return t;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running animation prescaler: tick is high for one cycle every DIV cycles.
module tick_divider #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   // At DIV=1 the counter is a single bit pinned at zero, so tick is constant 1.
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick  = (cnt_q == LAST);
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);

   // Prescaler count, wrapping from DIV-1 back to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/thunderbird_seq.sv
// Tail-light sequencer: sequential turn indication, hazard flash and brake
// overlay for LAMPS lamps per side, stepping once per prescaler tick.
module thunderbird_seq
   import thunderbird_pkg::*;
#(
   parameter int LAMPS = 3,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left,
   input  logic             right,
   input  logic             hazard,
   input  logic             brake,
   output logic [LAMPS-1:0] la,
   output logic [LAMPS-1:0] ra,
   output logic             busy
);

   localparam int KW = $clog2(LAMPS + 1);
   localparam logic [KW-1:0]    K_LAST = KW'(LAMPS);
   localparam logic [LAMPS-1:0] ALL_ON = '1;

   logic             tick;
   state_e           st_q, st_d;
   logic [KW-1:0]    k_q, k_d;
   logic [LAMPS-1:0] la_q, la_d;
   logic [LAMPS-1:0] ra_q, ra_d;
   logic             busy_q;

   tick_divider #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   // Next state and step counter; inputs are only looked at on tick cycles.
   always_comb begin
      st_d = st_q;
      k_d  = k_q;
      if (tick) begin
         unique case (st_q)
            IDLE: begin
               if (hazard || (left && right)) begin
                  st_d = HAZ;
                  k_d  = '0;
               end else if (left) begin
                  st_d = LEFT;
                  k_d  = KW'(1);
               end else if (right) begin
                  st_d = RIGHT;
                  k_d  = KW'(1);
               end
            end
            LEFT, RIGHT: begin
               // A started sequence runs to completion unless hazard aborts it.
               if (k_q == K_LAST) begin
                  st_d = IDLE;
                  k_d  = '0;
               end else if (hazard) begin
                  st_d = HAZ;
                  k_d  = '0;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
            HAZ: begin
               st_d = IDLE;
               k_d  = '0;
            end
            default: begin
               st_d = IDLE;
               k_d  = '0;
            end
         endcase
      end
   end

   // Lamp pattern from the next state, then brake lights any idle side.
   always_comb begin
      la_d = '0;
      ra_d = '0;
      unique case (st_d)
         LEFT:    la_d = LAMPS'(therm(int'(k_d), LAMPS));
         RIGHT:   ra_d = LAMPS'(therm(int'(k_d), LAMPS));
         HAZ: begin
            la_d = ALL_ON;
            ra_d = ALL_ON;
         end
         default: ;
      endcase
      if (brake) begin
         if ((st_d == IDLE) || (st_d == RIGHT)) la_d = ALL_ON;
         if ((st_d == IDLE) || (st_d == LEFT))  ra_d = ALL_ON;
      end
   end

   // State, step counter and registered lamp/busy outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q   <= IDLE;
         k_q    <= '0;
         la_q   <= '0;
         ra_q   <= '0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         k_q    <= k_d;
         la_q   <= la_d;
         ra_q   <= ra_d;
         busy_q <= (st_d != IDLE);
      end
   end

   assign la   = la_q;
   assign ra   = ra_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_thunderbird_seq.sv
// Bench for thunderbird_seq: three instances (3/1, 4/4, 3/2 lamps/div) with a
// behavioural model feeding a scoreboard queue of expected outputs.
module tb_thunderbird_seq;

   typedef struct packed {
      logic [3:0] la;
      logic [3:0] ra;
      logic       busy;
   } exp_t;

   typedef struct {
      int st;   // 0 idle, 1 left, 2 right, 3 hazard
      int k;
      int cnt;
   } mdl_t;

   logic clk;
   logic a_rst, a_l, a_r, a_h, a_b;
   logic b_rst, b_l, b_r, b_h, b_b;
   logic c_rst, c_l, c_r, c_h, c_b;
   logic [2:0] a_la, a_ra;
   logic [3:0] b_la, b_ra;
   logic [2:0] c_la, c_ra;
   logic a_busy, b_busy, c_busy;

   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   mdl_t ma, mb, mc;

   thunderbird_seq #(.LAMPS(3), .DIV(1)) u_a (
      .clk(clk), .reset(a_rst), .left(a_l), .right(a_r), .hazard(a_h), .brake(a_b),
      .la(a_la), .ra(a_ra), .busy(a_busy));

   thunderbird_seq #(.LAMPS(4), .DIV(4)) u_b (
      .clk(clk), .reset(b_rst), .left(b_l), .right(b_r), .hazard(b_h), .brake(b_b),
      .la(b_la), .ra(b_ra), .busy(b_busy));

   thunderbird_seq #(.LAMPS(3), .DIV(2)) u_c (
      .clk(clk), .reset(c_rst), .left(c_l), .right(c_r), .hazard(c_h), .brake(c_b),
      .la(c_la), .ra(c_ra), .busy(c_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   function automatic mdl_t mnext(input mdl_t m, input int lamps, input int div,
                                  input logic l, input logic r, input logic h);
      mdl_t n;
      bit   tk;
      n     = m;
      tk    = (m.cnt == div - 1);
      n.cnt = tk ? 0 : m.cnt + 1;
      if (tk) begin
         case (m.st)
            0: begin
               if (h || (l && r)) begin n.st = 3; n.k = 0; end
               else if (l)        begin n.st = 1; n.k = 1; end
               else if (r)        begin n.st = 2; n.k = 1; end
            end
            1, 2: begin
               if (m.k == lamps) begin n.st = 0; n.k = 0; end
               else if (h)       begin n.st = 3; n.k = 0; end
               else              n.k = m.k + 1;
            end
            default: begin n.st = 0; n.k = 0; end
         endcase
      end
      return n;
   endfunction

   function automatic exp_t mout(input mdl_t m, input int lamps, input logic b);
      exp_t       o;
      logic [3:0] all, pat;
      all = 4'((1 << lamps) - 1);
      pat = 4'((1 << m.k) - 1);
      o   = '0;
      case (m.st)
         1: o.la = pat;
         2: o.ra = pat;
         3: begin o.la = all; o.ra = all; end
         default: ;
      endcase
      if (b) begin
         if (m.st == 0 || m.st == 2) o.la = all;
         if (m.st == 0 || m.st == 1) o.ra = all;
      end
      o.busy = (m.st != 0);
      return o;
   endfunction

   function automatic exp_t actual(input int sel);
      case (sel)
         0:       return {1'b0, a_la, 1'b0, a_ra, a_busy};
         1:       return {b_la, b_ra, b_busy};
         default: return {1'b0, c_la, 1'b0, c_ra, c_busy};
      endcase
   endfunction

   // Advance all models one edge, push the selected instance's expectation,
   // then wait for the edge and settle.
   task automatic step(input int sel);
      exp_t ea, eb, ec;
      if (a_rst) begin ma = '{0, 0, 0}; ea = '0; end
      else begin ma = mnext(ma, 3, 1, a_l, a_r, a_h); ea = mout(ma, 3, a_b); end
      if (b_rst) begin mb = '{0, 0, 0}; eb = '0; end
      else begin mb = mnext(mb, 4, 4, b_l, b_r, b_h); eb = mout(mb, 4, b_b); end
      if (c_rst) begin mc = '{0, 0, 0}; ec = '0; end
      else begin mc = mnext(mc, 3, 2, c_l, c_r, c_h); ec = mout(mc, 3, c_b); end
      case (sel)
         0:       exp_q.push_back(ea);
         1:       exp_q.push_back(eb);
         default: exp_q.push_back(ec);
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e, act;
      a_b = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(0);
         e = exp_q.pop_front(); act = actual(0); checks++;
         if (act !== e) begin errors++; $display("FAIL reset_sb[%0d]: got %b want %b", i, act, e); end
      end
      checks++;
      if (a_la !== 3'b000 || a_ra !== 3'b000 || a_busy !== 1'b0) begin
         errors++; $display("FAIL reset_a: got la=%b ra=%b busy=%b want 000 000 0", a_la, a_ra, a_busy);
      end
      checks++;
      if (b_la !== 4'b0000 || b_ra !== 4'b0000 || b_busy !== 1'b0) begin
         errors++; $display("FAIL reset_b: got la=%b ra=%b busy=%b want 0000 0000 0", b_la, b_ra, b_busy);
      end
      #2;
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      a_b = 1'b0;
   endtask

   task automatic test_left();
      exp_t       e, act;
      logic [2:0] tl[8] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
      a_l = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(0);
         e = exp_q.pop_front(); act = actual(0); checks++;
         if (act !== e) begin errors++; $display("FAIL left_sb[%0d]: got %b want %b", i, act, e); end
         checks++;
         if (a_la !== tl[i] || a_ra !== 3'b000 || a_busy !== (tl[i] != 3'b000)) begin
            errors++; $display("FAIL left_seq[%0d]: got la=%b ra=%b busy=%b want la=%b ra=000", i, a_la, a_ra, a_busy, tl[i]);
         end
      end
      a_l = 1'b0;
   endtask

   task automatic test_hazard();
      exp_t       e, act;
      logic [2:0] want;
      for (int p = 0; p < 2; p++) begin
         if (p == 0) begin a_l = 1'b1; a_r = 1'b1; end
         else        begin a_l = 1'b0; a_r = 1'b0; a_h = 1'b1; end
         for (int i = 0; i < 6; i++) begin
            step(0);
            e = exp_q.pop_front(); act = actual(0); checks++;
            if (act !== e) begin errors++; $display("FAIL haz_sb[%0d.%0d]: got %b want %b", p, i, act, e); end
            want = (i % 2 == 0) ? 3'b111 : 3'b000;
            checks++;
            if (a_la !== want || a_ra !== want) begin
               errors++; $display("FAIL haz_flash[%0d.%0d]: got la=%b ra=%b want %b", p, i, a_la, a_ra, want);
            end
         end
      end
      a_l = 1'b0; a_r = 1'b0; a_h = 1'b0;
   endtask

   task automatic test_brake();
      exp_t       e, act;
      logic [2:0] bl[4] = '{3'b001, 3'b011, 3'b111, 3'b111};
      a_b = 1'b1; a_l = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 4) a_l = 1'b0;
         if (i == 6) a_h = 1'b1;
         if (i == 10) begin a_h = 1'b0; a_b = 1'b0; end
         step(0);
         e = exp_q.pop_front(); act = actual(0); checks++;
         if (act !== e) begin errors++; $display("FAIL brake_sb[%0d]: got %b want %b", i, act, e); end
         if (i < 4) begin
            checks++;
            if (a_la !== bl[i] || a_ra !== 3'b111) begin
               errors++; $display("FAIL brake_left[%0d]: got la=%b ra=%b want la=%b ra=111", i, a_la, a_ra, bl[i]);
            end
         end else if (i < 10) begin
            checks++;
            if (a_la !== 3'b111 || a_ra !== 3'b111) begin
               errors++; $display("FAIL brake_idle_haz[%0d]: got la=%b ra=%b want 111 111", i, a_la, a_ra);
            end
         end
      end
   endtask

   task automatic test_abort();
      exp_t e, act;
      a_l = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin a_l = 1'b0; a_h = 1'b1; end
         if (i == 3) a_h = 1'b0;
         step(0);
         e = exp_q.pop_front(); act = actual(0); checks++;
         if (act !== e) begin errors++; $display("FAIL abort_sb[%0d]: got %b want %b", i, act, e); end
      end
      a_h = 1'b0;
   endtask

   task automatic test_pulse();
      exp_t       e, act;
      logic [3:0] want;
      // Align so that the next edge is a tick of the DIV=4 instance.
      for (int g = 0; g < 4 && mb.cnt != 3; g++) begin
         step(1);
         e = exp_q.pop_front(); act = actual(1); checks++;
         if (act !== e) begin errors++; $display("FAIL pulse_align[%0d]: got %b want %b", g, act, e); end
      end
      b_r = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step(1);
         b_r = 1'b0;
         e = exp_q.pop_front(); act = actual(1); checks++;
         if (act !== e) begin errors++; $display("FAIL pulse_sb[%0d]: got %b want %b", i, act, e); end
         want = (i < 16) ? 4'((1 << (i / 4 + 1)) - 1) : 4'b0000;
         checks++;
         if (b_ra !== want || b_la !== 4'b0000 || b_busy !== (i < 16)) begin
            errors++; $display("FAIL pulse_seq[%0d]: got ra=%b la=%b busy=%b want ra=%b la=0000", i, b_ra, b_la, b_busy, want);
         end
      end
      // Pulse on a non-tick edge only: must be ignored.
      for (int g = 0; g < 4 && mb.cnt != 0; g++) begin
         step(1);
         e = exp_q.pop_front(); act = actual(1); checks++;
         if (act !== e) begin errors++; $display("FAIL nontick_align[%0d]: got %b want %b", g, act, e); end
      end
      b_r = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         b_r = 1'b0;
         e = exp_q.pop_front(); act = actual(1); checks++;
         if (act !== e) begin errors++; $display("FAIL nontick_sb[%0d]: got %b want %b", i, act, e); end
         checks++;
         if (b_ra !== 4'b0000 || b_busy !== 1'b0) begin
            errors++; $display("FAIL nontick_ignore[%0d]: got ra=%b busy=%b want 0000 0", i, b_ra, b_busy);
         end
      end
      // Brake acts on the next edge even when that edge is not a tick.
      for (int g = 0; g < 4 && mb.cnt != 0; g++) begin
         step(1);
         e = exp_q.pop_front(); act = actual(1); checks++;
         if (act !== e) begin errors++; $display("FAIL brake_align[%0d]: got %b want %b", g, act, e); end
      end
      b_b = 1'b1;
      step(1);
      e = exp_q.pop_front(); act = actual(1); checks++;
      if (act !== e) begin errors++; $display("FAIL brake_b_on_sb: got %b want %b", act, e); end
      checks++;
      if (b_la !== 4'b1111 || b_ra !== 4'b1111) begin
         errors++; $display("FAIL brake_b_on: got la=%b ra=%b want 1111 1111", b_la, b_ra);
      end
      b_b = 1'b0;
      step(1);
      e = exp_q.pop_front(); act = actual(1); checks++;
      if (act !== e) begin errors++; $display("FAIL brake_b_off_sb: got %b want %b", act, e); end
      checks++;
      if (b_la !== 4'b0000 || b_ra !== 4'b0000) begin
         errors++; $display("FAIL brake_b_off: got la=%b ra=%b want 0000 0000", b_la, b_ra);
      end
   endtask

   task automatic test_async_reset();
      exp_t       e, act;
      logic [2:0] rl[2] = '{3'b000, 3'b001};
      c_l = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(2);
         e = exp_q.pop_front(); act = actual(2); checks++;
         if (act !== e) begin errors++; $display("FAIL pre_reset_sb[%0d]: got %b want %b", i, act, e); end
      end
      #3;
      c_rst = 1'b1;
      #1;
      checks++;
      if (c_la !== 3'b000 || c_ra !== 3'b000 || c_busy !== 1'b0) begin
         errors++; $display("FAIL async_reset: got la=%b ra=%b busy=%b want 000 000 0", c_la, c_ra, c_busy);
      end
      mc = '{0, 0, 0};
      step(2);
      e = exp_q.pop_front(); act = actual(2); checks++;
      if (act !== e) begin errors++; $display("FAIL reset_hold_sb: got %b want %b", act, e); end
      #2;
      c_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(2);
         e = exp_q.pop_front(); act = actual(2); checks++;
         if (act !== e) begin errors++; $display("FAIL post_reset_sb[%0d]: got %b want %b", i, act, e); end
         if (i < 2) begin
            checks++;
            if (c_la !== rl[i]) begin
               errors++; $display("FAIL post_reset_first[%0d]: got la=%b want %b", i, c_la, rl[i]);
            end
         end
      end
      c_l = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_l = 1'b0; a_r = 1'b0; a_h = 1'b0; a_b = 1'b0;
      b_l = 1'b0; b_r = 1'b0; b_h = 1'b0; b_b = 1'b0;
      c_l = 1'b0; c_r = 1'b0; c_h = 1'b0; c_b = 1'b0;
      ma = '{0, 0, 0}; mb = '{0, 0, 0}; mc = '{0, 0, 0};
      test_reset();
      test_left();
      test_hazard();
      test_brake();
      test_abort();
      test_pulse();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
